// File: rtl/boot_loader.sv
// Boot loader: SPI mode-0 initiator that reads a length-prefixed image from an
// EEPROM and writes it word by word into SRAM through the boot port.
module boot_loader #(
    parameter int          HALF_DIV   = 2,
    parameter logic [15:0] START_ADDR = 16'h0000,
    parameter logic [16:0] MAX_WORDS  = 17'h10000,
    parameter logic [7:0]  READ_CMD   = 8'h03
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spiSDI,
    output logic        spiSCK,
    output logic        spiSCS,
    output logic        spiSDO,
    output logic [15:0] bootAddr,
    output logic [15:0] bootData,
    output logic        bootWr,
    output logic        bootEn,
    output logic        isBooted
);

    localparam int                DIV_W    = $clog2(HALF_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [23:0]       FRAME    = {READ_CMD, START_ADDR};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_HDR,
        S_DATA,
        S_FINISH,
        S_CLOSE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               sck_q, sck_d;
    logic               scs_q, scs_d;
    logic               sdo_q, sdo_d;
    logic [23:0]        frame_q, frame_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [15:0]        shift_q, shift_d;
    logic [16:0]        n_words_q, n_words_d;
    logic [16:0]        word_cnt_q, word_cnt_d;
    logic               wr_pend_q, wr_pend_d;
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        data_q, data_d;
    logic               wr_q, wr_d;
    logic               booted_q, booted_d;

    logic               running;
    logic               tick;
    logic               rise;
    logic               fall;
    logic [15:0]        sample_word;
    logic [16:0]        hdr_len;
    logic [16:0]        hdr_clamped;
    logic [16:0]        word_next;

    always_comb begin
        running     = (state_q == S_CMD) || (state_q == S_HDR) ||
                      (state_q == S_DATA) || (state_q == S_FINISH);
        tick        = running && (div_q == DIV_LAST);
        rise        = tick && !sck_q;
        fall        = tick && sck_q;
        sample_word = {shift_q[14:0], spiSDI};
        hdr_len     = {1'b0, sample_word};
        hdr_clamped = (hdr_len > MAX_WORDS) ? MAX_WORDS : hdr_len;
        word_next   = word_cnt_q + 17'd1;

        state_d    = state_q;
        div_d      = div_q;
        sck_d      = sck_q;
        scs_d      = scs_q;
        sdo_d      = sdo_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        n_words_d  = n_words_q;
        word_cnt_d = word_cnt_q;
        wr_pend_d  = wr_pend_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = 1'b0;
        booted_d   = booted_q;

        // SCK free-runs through every active phase, including the wait for the final fall
        if (running) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) sck_d = !sck_q;
        end

        case (state_q)
            S_IDLE: begin
                state_d   = S_CMD;
                scs_d     = 1'b0;
                sdo_d     = FRAME[23];
                frame_d   = FRAME;
                div_d     = '0;
                sck_d     = 1'b0;
                bit_cnt_d = '0;
            end
            S_CMD: begin
                if (fall) begin
                    frame_d = frame_q << 1;
                    if (bit_cnt_q == 5'd23) begin
                        sdo_d     = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = S_HDR;
                    end else begin
                        sdo_d     = frame_q[22];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_HDR: begin
                if (rise) begin
                    shift_d = sample_word;
                    if (bit_cnt_q == 5'd15) begin
                        bit_cnt_d  = '0;
                        n_words_d  = hdr_clamped;
                        word_cnt_d = '0;
                        state_d    = (hdr_clamped == 17'd0) ? S_FINISH : S_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_DATA: begin
                // strobe lands one cycle after the 16th sample; next rise is >= 2*HALF_DIV away
                if (wr_pend_q) begin
                    wr_d       = 1'b1;
                    addr_d     = word_cnt_q[15:0];
                    data_d     = shift_q;
                    word_cnt_d = word_next;
                    wr_pend_d  = 1'b0;
                    if (word_next == n_words_q) state_d = S_FINISH;
                end
                if (rise) begin
                    shift_d = sample_word;
                    if (bit_cnt_q == 5'd15) begin
                        bit_cnt_d = '0;
                        wr_pend_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_FINISH: begin
                if (fall) state_d = S_CLOSE;
            end
            S_CLOSE: begin
                scs_d    = 1'b1;
                booted_d = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            sck_q      <= 1'b0;
            scs_q      <= 1'b1;
            sdo_q      <= 1'b0;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            n_words_q  <= '0;
            word_cnt_q <= '0;
            wr_pend_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            booted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            sck_q      <= sck_d;
            scs_q      <= scs_d;
            sdo_q      <= sdo_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            n_words_q  <= n_words_d;
            word_cnt_q <= word_cnt_d;
            wr_pend_q  <= wr_pend_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            booted_q   <= booted_d;
        end
    end

    assign spiSCK   = sck_q;
    assign spiSCS   = scs_q;
    assign spiSDO   = sdo_q;
    assign bootAddr = addr_q;
    assign bootData = data_q;
    assign bootWr   = wr_q;
    assign bootEn   = wr_q;
    assign isBooted = booted_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: three parameterisations share one EEPROM model; a
// scoreboard queue of expected SRAM writes is drained by a write monitor.
module tb_boot_loader;

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    logic [2:0] sdi = 3'b000;
    logic [2:0] sck, scs, sdo, wr, en, booted;
    logic [2:0][15:0] addr, data;

    int errors = 0;
    int checks = 0;

    logic [15:0] rom [3][6];
    int          rises [3];
    int          kbits [3];
    int          phase [3];
    logic [23:0] cmd   [3];
    logic [2:0]  sck_prev = 3'b000;
    logic [2:0]  wr_prev  = 3'b000;
    logic [33:0] exp_q [$];

    always #5 clk = ~clk;

    boot_loader #(.HALF_DIV(2)) dut0 (
        .clk(clk), .rst(rst[0]), .spiSDI(sdi[0]), .spiSCK(sck[0]), .spiSCS(scs[0]),
        .spiSDO(sdo[0]), .bootAddr(addr[0]), .bootData(data[0]), .bootWr(wr[0]),
        .bootEn(en[0]), .isBooted(booted[0]));

    boot_loader #(.HALF_DIV(2), .MAX_WORDS(17'd4)) dut1 (
        .clk(clk), .rst(rst[1]), .spiSDI(sdi[1]), .spiSCK(sck[1]), .spiSCS(scs[1]),
        .spiSDO(sdo[1]), .bootAddr(addr[1]), .bootData(data[1]), .bootWr(wr[1]),
        .bootEn(en[1]), .isBooted(booted[1]));

    boot_loader #(.HALF_DIV(5)) dut2 (
        .clk(clk), .rst(rst[2]), .spiSDI(sdi[2]), .spiSCK(sck[2]), .spiSCS(scs[2]),
        .spiSDO(sdo[2]), .bootAddr(addr[2]), .bootData(data[2]), .bootWr(wr[2]),
        .bootEn(en[2]), .isBooted(booted[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // EEPROM model: samples SDO on SCK rise, drives SDI after SCK fall, checks phase widths
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int hd, j, b;
            hd = (i == 2) ? 5 : 2;
            if (rst[i]) begin
                rises[i] = 0;
                cmd[i]   = '0;
            end
            if (scs[i]) begin
                kbits[i] = 0;
                phase[i] = -1;
                sdi[i]   = 1'b0;
            end else begin
                phase[i]++;
                if (sck[i] != sck_prev[i]) begin
                    chk($sformatf("sck_phase_dut%0d", i), 64'(phase[i]), 64'(hd));
                    phase[i] = 0;
                end
                if (sck[i] && !sck_prev[i]) begin
                    if (kbits[i] < 24) cmd[i] = {cmd[i][22:0], sdo[i]};
                    kbits[i]++;
                    rises[i]++;
                end
                if (!sck[i] && sck_prev[i] && kbits[i] >= 24) begin
                    j = (kbits[i] - 24) / 16;
                    b = 15 - ((kbits[i] - 24) % 16);
                    sdi[i] = (j < 6) ? rom[i][j][b] : 1'b0;
                end
            end
            sck_prev[i] = sck[i];
        end
    end

    // write monitor / scoreboard
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wr[i]) begin
                logic [33:0] e;
                chk($sformatf("boot_en_dut%0d", i), 64'(en[i]), 64'd1);
                chk($sformatf("wr_single_cycle_dut%0d", i), 64'(wr_prev[i]), 64'd0);
                if (exp_q.size() == 0) begin
                    chk($sformatf("unexpected_write_dut%0d", i), {30'd0, 2'(i), addr[i], data[i]}, 64'h3_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("write_dut%0d", i), {30'd0, 2'(i), addr[i], data[i]}, {30'd0, e});
                end
            end
            wr_prev[i] = wr[i];
        end
    end

    task automatic push_wr(input int i, input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back({2'(i), a, d});
    endtask

    task automatic run_boot(input int i, input int exp_rises);
        int n;
        @(negedge clk);
        rst[i] = 1'b0;
        n = 0;
        while (!booted[i] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("boot_timeout_dut%0d", i), 64'(booted[i]), 64'd1);
        repeat (4) @(negedge clk);
        chk($sformatf("sck_rises_dut%0d", i), 64'(rises[i]), 64'(exp_rises));
        chk($sformatf("cmd_bits_dut%0d", i), 64'(cmd[i]), 64'h030000);
        chk($sformatf("idle_bus_dut%0d", i), {61'd0, scs[i], sck[i], sdo[i]}, 64'b100);
        chk($sformatf("all_writes_seen_dut%0d", i), 64'(exp_q.size()), 64'd0);
        chk($sformatf("booted_sticky_dut%0d", i), 64'(booted[i]), 64'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 6; j++) rom[i][j] = 16'h0000;
        rom[0][0] = 16'h0002; rom[0][1] = 16'hBEEF; rom[0][2] = 16'h1234;
        rom[1][0] = 16'hFFFF; rom[1][1] = 16'h1111; rom[1][2] = 16'h2222;
        rom[1][3] = 16'h3333; rom[1][4] = 16'h4444; rom[1][5] = 16'h5555;
        rom[2][0] = 16'h0001; rom[2][1] = 16'hA5C3;

        // reset held for 10 cycles: outputs at reset values, no SCK activity
        repeat (10) begin
            @(negedge clk);
            chk("reset_outputs", {scs[0], sck[0], sdo[0], addr[0], data[0], wr[0], en[0], booted[0]},
                {1'b1, 2'b00, 32'h0, 3'b000});
            chk("reset_no_sck", 64'(rises[0]), 64'd0);
        end

        // two-word image
        push_wr(0, 16'h0000, 16'hBEEF);
        push_wr(0, 16'h0001, 16'h1234);
        run_boot(0, 72);
        chk("hold_last_write", {addr[0], data[0]}, {16'h0001, 16'h1234});

        // reset in the middle of word 1, then full restart
        @(negedge clk);
        rst[0] = 1'b1;
        repeat (3) @(negedge clk);
        push_wr(0, 16'h0000, 16'hBEEF);
        @(negedge clk);
        rst[0] = 1'b0;
        n = 0;
        while (rises[0] < 64 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_word1", 64'(rises[0] >= 64), 64'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("midreset_bus", {scs[0], sck[0], wr[0], booted[0]}, 4'b1000);
        chk("midreset_sticky_clear", {addr[0], data[0]}, 32'h0);
        @(negedge clk);
        push_wr(0, 16'h0000, 16'hBEEF);
        push_wr(0, 16'h0001, 16'h1234);
        run_boot(0, 72);

        // empty image
        rst[0] = 1'b1;
        rom[0][0] = 16'h0000;
        repeat (2) @(negedge clk);
        run_boot(0, 40);

        // header clamped by MAX_WORDS=4
        for (int a = 0; a < 4; a++) push_wr(1, 16'(a), rom[1][a+1]);
        run_boot(1, 104);

        // slow SCK
        push_wr(2, 16'h0000, 16'hA5C3);
        run_boot(2, 56);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
